// File: rtl/hidden_cpu_feeder_pkg.sv
// Shared types and constants for the HiddenCPU feeder.
// State encoding, io_in bit positions, instruction width.
package hidden_cpu_pkg;

  localparam int INSTR_W     = 6;
  localparam int CPU_CLK_BIT = 0;
  localparam int CPU_RST_BIT = 1;
  localparam int INSTR_LSB   = 2;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    RUN,
    DRAIN,
    FIN
  } state_e;

  function automatic logic [7:0] io_byte(
    input logic [INSTR_W-1:0] ins,
    input logic               r,
    input logic               c
  );
    logic [7:0] b;
    b = '0;
    b[CPU_CLK_BIT] = c;
    b[CPU_RST_BIT] = r;
    b[INSTR_LSB +: INSTR_W] = ins;
    return b;
  endfunction

endpackage

// File: rtl/hidden_cpu_feeder_if.sv
// Program load port: valid/ready with data and last marker.
// master = host side, slave = feeder side.
interface hidden_cpu_feeder_if;
  import hidden_cpu_pkg::*;

  logic               load_valid;
  logic               load_ready;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/hidden_cpu_prog_buf.sv
// Program storage: DEPTH x INSTR_W, sync write, comb read.
// Ports: clk, we_i/waddr_i/wdata_i write, raddr_i/rdata_o read.
module hidden_cpu_prog_buf
  import hidden_cpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hidden_cpu_feeder.sv
// Host driver for the HiddenCPU pins: loads, resets, streams, captures.
// Ports: clk/rst, ld load port, clear/start, status, cpu_io_in/out.
module hidden_cpu_feeder
  import hidden_cpu_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  hidden_cpu_feeder_if.slave  ld,
  input  logic                clear,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         prog_len,
  output logic [7:0]          result,
  output logic [7:0]          cpu_io_in,
  input  logic [7:0]          cpu_io_out
);

  localparam int CW = $clog2(2 * RST_CYCLES) + 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] RST_LAST = CW'(2 * RST_CYCLES - 1);

  state_e             state_q;
  logic [AW:0]        wptr_q;
  logic [AW:0]        plen_q;
  logic [AW-1:0]      rptr_q;
  logic               phase_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         result_q;
  logic [7:0]         io_q;

  logic               accept;
  logic               we;
  logic               last_k;
  logic [AW-1:0]      raddr;
  logic [INSTR_W-1:0] rdata;

  assign ld.load_ready = (state_q == IDLE) && (wptr_q < FULL);
  assign accept = ld.load_valid && ld.load_ready;
  assign we     = accept && !clear;
  assign last_k = ({1'b0, rptr_q} == plen_q - (AW + 1)'(1));

  // Reads happen only when the next instruction is loaded into
  // io_in: mem[0] leaving RST, mem[rptr+1] at a RUN high phase.
  assign raddr = (state_q == RUN) ? rptr_q + AW'(1) : '0;

  hidden_cpu_prog_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (ld.load_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      plen_q   <= '0;
      rptr_q   <= '0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      io_q     <= io_byte('0, 1'b1, 1'b0);
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          io_q <= '0;
          if (clear) begin
            wptr_q <= '0;
            plen_q <= '0;
          end else begin
            if (accept) begin
              wptr_q <= wptr_q + (AW + 1)'(1);
              if (ld.load_last || plen_q != '0 ||
                  wptr_q == FULL - (AW + 1)'(1))
                plen_q <= wptr_q + (AW + 1)'(1);
            end
            if (start && plen_q != '0) begin
              state_q <= RST;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              io_q    <= io_byte('0, 1'b1, 1'b0);
            end
          end
        end
        RST: begin
          if (cnt_q == RST_LAST) begin
            state_q <= RUN;
            rptr_q  <= '0;
            phase_q <= 1'b0;
            io_q    <= io_byte(rdata, 1'b0, 1'b0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
            io_q  <= io_byte('0, 1'b1, ~io_q[CPU_CLK_BIT]);
          end
        end
        RUN: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            io_q    <= io_byte(io_q[INSTR_LSB +: INSTR_W],
                               1'b0, 1'b1);
          end else if (last_k) begin
            state_q <= DRAIN;
            io_q    <= io_byte(io_q[INSTR_LSB +: INSTR_W],
                               1'b0, 1'b0);
          end else begin
            phase_q <= 1'b0;
            rptr_q  <= rptr_q + AW'(1);
            io_q    <= io_byte(rdata, 1'b0, 1'b0);
          end
        end
        DRAIN: begin
          result_q <= cpu_io_out;
          state_q  <= FIN;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          io_q     <= '0;
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign prog_len  = plen_q;
  assign result    = result_q;
  assign cpu_io_in = io_q;

endmodule
